// File: rtl/gray_step_encoder.sv
// gray_step_encoder: walks a registered Gray bus to a requested binary target one single-bit step at a time
// Ports: clk/rst (async active-high reset), bin_in/in_valid/in_ready request handshake,
// gray_out registered Gray code of the current position, busy while walking, done one-cycle completion pulse.
// Optional macro GRAY_STEP_SHORTPATH_EN: walk in the shorter wrap direction instead of always counting up.
module gray_step_encoder #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, STEP, HOLD} state_t;
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d, tgt_q, tgt_d, gray_q, gray_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;
`ifdef GRAY_STEP_SHORTPATH_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic             dn_q, dn_d;
    logic [WIDTH-1:0] d_up;
    assign d_up = bin_in - cur_q;
`endif
    assign accept   = in_valid && (state_q == IDLE);
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign gray_out = gray_q;
    assign done     = done_q;
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef GRAY_STEP_SHORTPATH_EN
        dn_d    = dn_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                tgt_d = bin_in;
                if (bin_in == cur_q) done_d = 1'b1;
                else state_d = STEP;
`ifdef GRAY_STEP_SHORTPATH_EN
                // a tie at exactly half the code space goes up
                dn_d = d_up > HALF;
`endif
            end
            STEP: begin
`ifdef GRAY_STEP_SHORTPATH_EN
                cur_d = dn_q ? cur_q - 1'b1 : cur_q + 1'b1;
`else
                cur_d = cur_q + 1'b1;
`endif
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: if (cnt_q >= CW'(HOLD_CYCLES - 1)) begin
                state_d = (cur_q == tgt_q) ? IDLE : STEP;
                done_d  = (cur_q == tgt_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // gray register tracks the next position so it changes on the same edge as cur
        gray_d = cur_d ^ (cur_d >> 1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
`ifdef GRAY_STEP_SHORTPATH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dn_q <= 1'b0;
        else dn_q <= dn_d;
    end
`endif
endmodule
